// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
//
// Writer side of the instruction memory. Accepts a program image as a byte
// stream and writes it, one 32-bit word at a time, into the instruction RAM
// write port. The CPU core is held in reset until a complete image whose
// checksum matches has been loaded.
//
// Stream format (little-endian):
//   LEN_LO, LEN_HI        16-bit word count N
//   N x 4 data bytes      each word LSB first
//   CSUM                  XOR of all data bytes (length bytes excluded)
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      one-cycle pulse that begins a new load (ignored while busy)
//   in_valid   in_data holds a byte
//   in_data    stream byte
//   in_ready   loader can accept a byte this cycle
//   mem_we     instruction RAM write enable, one-cycle pulse
//   mem_addr   word index (not a byte address), zero-extended
//   mem_wdata  instruction word
//   busy       load in progress
//   done       image loaded and verified
//   error      load failed (length overflow or checksum mismatch)
//   cpu_rst_n  active-low reset to the CPU core
// ----------------------------------------------------------------------------
module imem_loader #(
    parameter int ROM_SIZE = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_rst_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [16:0] ROM_WORDS = 17'(ROM_SIZE);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] len;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [7:0]  csum;
    logic [23:0] asm_lo;     // lower three lanes of the word being assembled

    logic        xfer;
    logic [15:0] len_full;
    logic        len_over;
    logic        last_word;

    assign xfer      = in_valid && in_ready;
    // Full length as it will be once LEN_HI is captured this cycle.
    assign len_full  = {in_data, len[7:0]};
    assign len_over  = {1'b0, len_full} > ROM_WORDS;
    assign last_word = (word_idx + 16'd1) == len;

    // ---- state register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- next state and decoded in_ready ----
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_nxt = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                in_ready = 1'b1;
                if (xfer) begin
                    state_nxt = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                in_ready = 1'b1;
                if (xfer) begin
                    if (len_over) begin
                        state_nxt = S_ERROR;
                    end else if (len_full == 16'd0) begin
                        state_nxt = S_CSUM;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                // Stays ready during the write cycle: bytes may arrive back to back.
                in_ready = 1'b1;
                if (xfer && byte_cnt == 2'd3 && last_word) begin
                    state_nxt = S_CSUM;
                end
            end
            S_CSUM: begin
                in_ready = 1'b1;
                if (xfer) begin
                    state_nxt = (in_data == csum) ? S_DONE : S_ERROR;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ---- datapath, write port and status outputs ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len       <= 16'd0;
            word_idx  <= 16'd0;
            byte_cnt  <= 2'd0;
            csum      <= 8'd0;
            asm_lo    <= 24'd0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            cpu_rst_n <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        done      <= 1'b0;
                        error     <= 1'b0;
                        csum      <= 8'd0;
                        word_idx  <= 16'd0;
                        byte_cnt  <= 2'd0;
                        busy      <= 1'b1;
                        cpu_rst_n <= 1'b0;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        len[7:0] <= in_data;
                    end
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        len[15:8] <= in_data;
                        if (len_over) begin
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        csum     <= csum ^ in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: asm_lo[7:0]   <= in_data;
                            2'd1: asm_lo[15:8]  <= in_data;
                            2'd2: asm_lo[23:16] <= in_data;
                            default: begin
                                // Fourth byte completes the word; the write
                                // issues on the following cycle.
                                mem_we    <= 1'b1;
                                mem_addr  <= 32'(word_idx);
                                mem_wdata <= {in_data, asm_lo};
                                word_idx  <= word_idx + 16'd1;
                            end
                        endcase
                    end
                end
                S_CSUM: begin
                    if (xfer) begin
                        busy <= 1'b0;
                        if (in_data == csum) begin
                            done      <= 1'b1;
                            cpu_rst_n <= 1'b1;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int ROM_SIZE = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_rst_n;

    imem_loader #(.ROM_SIZE(ROM_SIZE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .cpu_rst_n (cpu_rst_n)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  stream[$];
    logic [63:0] got[$];
    logic [63:0] exp_w[$];
    logic        exp_ok;
    int          gap_max = 0;

    // Every RAM write observed, as {addr, data}.
    always @(negedge clk) begin
        if (mem_we === 1'b1) got.push_back({mem_addr, mem_wdata});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: what the image in 'stream' should produce.
    task automatic build_model();
        int n;
        logic [7:0]  cs;
        logic [31:0] w;
        exp_w.delete();
        n = int'(stream[0]) + 256 * int'(stream[1]);
        if (n > ROM_SIZE) begin
            exp_ok = 1'b0;
            return;
        end
        cs = 8'd0;
        for (int i = 0; i < n; i++) begin
            w = 32'd0;
            for (int b = 0; b < 4; b++) begin
                w  = w | (32'(stream[2 + 4*i + b]) << (8*b));
                cs = cs ^ stream[2 + 4*i + b];
            end
            exp_w.push_back({32'(i), w});
        end
        exp_ok = (stream[2 + 4*n] == cs);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Sends every byte of 'stream'; start_at >= 0 also raises start with that byte.
    task automatic send_stream(input int start_at);
        int k;
        for (int i = 0; i < stream.size(); i++) begin
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
            in_valid = 1'b1;
            in_data  = stream[i];
            if (i == start_at) start = 1'b1;
            k = 0;
            while (in_ready !== 1'b1 && k < 50) begin
                @(negedge clk);
                start = 1'b0;
                k++;
            end
            if (k >= 50) begin
                chk("ready_timeout", 64'd0, 64'd1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            start    = 1'b0;
            in_valid = 1'b0;
        end
    endtask

    task automatic check_result(input string tag);
        repeat (2) @(negedge clk);
        chk({tag, "_nwrites"}, 64'(got.size()), 64'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < got.size(); i++)
            chk({tag, "_write"}, got[i], exp_w[i]);
        chk({tag, "_done"}, 64'(done), 64'(exp_ok));
        chk({tag, "_error"}, 64'(error), 64'(!exp_ok));
        chk({tag, "_cpu_rst_n"}, 64'(cpu_rst_n), 64'(exp_ok));
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    endtask

    task automatic run_load(input string tag, input int start_at);
        got.delete();
        build_model();
        pulse_start();
        send_stream(start_at);
        check_result(tag);
    endtask

    task automatic set_nominal(input logic [7:0] cs);
        stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                   8'h93, 8'h05, 8'h20, 8'h00, 8'h00};
        stream[10] = cs;
    endtask

    task automatic set_random(input int n, input logic bad);
        logic [7:0] cs;
        logic [7:0] b;
        stream.delete();
        stream.push_back(8'(n));
        stream.push_back(8'(n >> 8));
        cs = 8'd0;
        for (int i = 0; i < 4*n; i++) begin
            b  = 8'($urandom_range(0, 255));
            cs = cs ^ b;
            stream.push_back(b);
        end
        stream.push_back(bad ? (cs ^ 8'(1 << $urandom_range(0, 7))) : cs);
    endtask

    initial begin
        // Power-on reset.
        #1;
        chk("por_outputs", 64'({in_ready, mem_we, busy, done, error, cpu_rst_n}), 64'd0);
        chk("por_addr_data", {mem_addr, mem_wdata}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 64'(in_ready), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);

        // Reset mid-stream: outputs drop without a clock edge.
        set_nominal(8'hB0);
        stream = stream[0:6];
        pulse_start();
        send_stream(-1);
        chk("mid_busy", 64'(busy), 64'd1);
        chk("mid_first_write", {mem_addr, mem_wdata}, {32'd0, 32'h00100513});
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", 64'({in_ready, mem_we, busy, done, error, cpu_rst_n}), 64'd0);
        chk("async_rst_addr_data", {mem_addr, mem_wdata}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd0);

        // Nominal load.
        set_nominal(8'hB0);
        run_load("nominal", -1);
        if (got.size() == 2) begin
            chk("nominal_w0", got[0], {32'd0, 32'h00100513});
            chk("nominal_w1", got[1], {32'd1, 32'h00200593});
        end else begin
            chk("nominal_count", 64'(got.size()), 64'd2);
        end
        chk("hold_addr_data", {mem_addr, mem_wdata}, {32'd1, 32'h00200593});

        // Bad checksum.
        set_nominal(8'hB1);
        run_load("badcsum", -1);
        chk("badcsum_error", 64'(error), 64'd1);

        // Length overflow.
        stream = '{8'h41, 8'h00};
        run_load("overflow", -1);
        chk("overflow_error", 64'(error), 64'd1);

        // Gaps on in_valid.
        gap_max = 3;
        set_nominal(8'hB0);
        run_load("gaps", -1);
        gap_max = 0;

        // Empty image.
        stream = '{8'h00, 8'h00, 8'h00};
        run_load("empty", -1);
        chk("empty_done", 64'(done), 64'd1);

        // Full memory.
        set_random(ROM_SIZE, 1'b0);
        run_load("full", -1);
        if (got.size() > 0) chk("full_last_addr", 64'(got[got.size()-1][63:32]), 64'(ROM_SIZE - 1));

        // Random images, random gaps, random checksum corruption.
        for (int r = 0; r < 6; r++) begin
            gap_max = $urandom_range(0, 2);
            set_random($urandom_range(1, 6), 1'($urandom_range(0, 1)));
            run_load("random", -1);
        end
        gap_max = 0;

        // start during DATA is ignored.
        set_nominal(8'hB0);
        run_load("start_in_data", 5);

        // Restart from DONE.
        got.delete();
        pulse_start();
        chk("restart_done", 64'(done), 64'd0);
        chk("restart_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        chk("restart_busy", 64'(busy), 64'd1);
        set_random(3, 1'b0);
        build_model();
        send_stream(-1);
        check_result("restart");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
